// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   - FSM state encoding (2 bits)
//   - default WIDTH/SLICE values and a helper that sizes the slice index register
package nibble_serial_adder_pkg;

  localparam int NSA_WIDTH_DEF = 32;
  localparam int NSA_SLICE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } nsa_state_e;

  // Width of an index that counts 0..n_slices-1; never narrower than 1 bit.
  function automatic int nsa_idx_w(input int n_slices);
    return (n_slices > 1) ? $clog2(n_slices) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_carry_slice.sv
// Combinational SLICE-bit adder with carry in/out.
// Ports:
//   a_i, b_i  : SLICE-bit operands
//   cin_i     : carry in
//   sum_o     : SLICE-bit sum
//   cout_o    : carry out
module carry_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit add per cycle, LSB slice first,
// carry registered between slices. Valid/ready handshake on both sides.
// Optional feature macro: NIBBLE_SERIAL_ADDER_SUB_EN adds the in_sub port (A-B).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (ready only while idle)
//   in_a, in_b            : operands
//   in_sub                : subtract select (only with NIBBLE_SERIAL_ADDER_SUB_EN)
//   out_valid/out_ready   : result handshake
//   out_sum               : A+B (or A-B) mod 2^WIDTH
//   out_carry             : carry out of MSB slice (subtract: 1 = no borrow)
//   out_ovf               : signed overflow
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_BUSY | adding slice idx_q each cycle
// ST_DONE | result held on outputs until out_ready
import nibble_serial_adder_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = NSA_WIDTH_DEF,
  parameter int SLICE = NSA_SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = nsa_idx_w(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  nsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             oc_q, oc_d;
  logic             ovf_q, ovf_d;

  logic             sub_w;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_c;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign sub_w = in_sub;
`else
  assign sub_w = 1'b0;
`endif

  assign sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign sl_b = b_q[int'(idx_q)*SLICE +: SLICE];

  carry_slice #(.SLICE(SLICE)) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .sum_o  (sl_s),
    .cout_o (sl_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    oc_d    = oc_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          a_d     = in_a;
          // Subtract is A + ~B + 1: invert B and seed the carry.
          b_d     = sub_w ? ~in_b : in_b;
          carry_d = sub_w;
          idx_d   = '0;
          oc_d    = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_BUSY: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = sl_s;
        carry_d = sl_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          oc_d    = sl_c;
          // sl_s[SLICE-1] is the final sum MSB, written this same cycle.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE-1] != a_q[WIDTH-1]);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      oc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      oc_q    <= oc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_carry = oc_q;
  assign out_ovf   = ovf_q;

endmodule
